// File: rtl/cpu_pkg.sv
// cpu_pkg: opcode/state types and instruction field extraction shared by the core
package cpu_pkg;
  typedef enum logic [2:0] {OP_HALT, OP_ADD, OP_SUB, OP_AND, OP_LDI, OP_BRZ, OP_JMP, OP_NOP} opcode_t;
  typedef enum logic [1:0] {ST_WAIT, ST_FETCH, ST_EXEC, ST_HALTED} state_t;
  function automatic logic [63:0] fmask(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction
  function automatic logic [63:0] f_op(input logic [63:0] i, input int rw);
    return (i >> (3 * rw)) & 64'd7;
  endfunction
  function automatic logic [63:0] f_ra(input logic [63:0] i, input int rw);
    return (i >> (2 * rw)) & fmask(rw);
  endfunction
  function automatic logic [63:0] f_rb(input logic [63:0] i, input int rw);
    return (i >> rw) & fmask(rw);
  endfunction
  function automatic logic [63:0] f_rd(input logic [63:0] i, input int rw);
    return i & fmask(rw);
  endfunction
  function automatic logic [63:0] f_tgt(input logic [63:0] i, input int rw);
    return i & fmask(2 * rw);
  endfunction
  function automatic logic [63:0] f_imm(input logic [63:0] i, input int rw);
    return (i >> rw) & fmask(2 * rw);
  endfunction
endpackage

// File: rtl/cpu_regfile.sv
// cpu_regfile: register file with two operand read ports, a debug read port and one write port
module cpu_regfile #(
  parameter int DATA_W = 6,
  parameter int NUM_REGS = 8,
  localparam int RIDX_W = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [RIDX_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [RIDX_W-1:0] ra,
  input  logic [RIDX_W-1:0] rb,
  input  logic [RIDX_W-1:0] rdbg,
  output logic [DATA_W-1:0] qa,
  output logic [DATA_W-1:0] qb,
  output logic [DATA_W-1:0] qdbg
);
  logic [DATA_W-1:0] r [NUM_REGS];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r <= '{default: '0};
    else if (we) r[wa] <= wd;
  assign qa = r[ra];
  assign qb = r[rb];
  assign qdbg = r[rdbg];
endmodule

// File: rtl/cpu_core.sv
// cpu_core: multi-cycle processor with tick/step advance, breakpoint halt/resume and retire counter
module cpu_core import cpu_pkg::*; #(
  parameter int DATA_W = 6,
  parameter int NUM_REGS = 8,
  parameter int IMEM_DEPTH = 64,
  parameter int CNT_W = 16,
  localparam int RIDX_W = $clog2(NUM_REGS),
  localparam int AW = $clog2(IMEM_DEPTH),
  localparam int IW = 3 + 3 * RIDX_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic              step_mode,
  input  logic              step,
  input  logic              resume,
  input  logic              bp_en,
  input  logic [AW-1:0]     bp_addr,
  output logic [AW-1:0]     imem_addr,
  input  logic [IW-1:0]     imem_data,
  input  logic [RIDX_W-1:0] dbg_sel,
  output logic [DATA_W-1:0] dbg_data,
  output logic [AW-1:0]     pc,
  output logic [IW-1:0]     ir,
  output logic [DATA_W-1:0] alu_out,
  output logic              halted,
  output logic [CNT_W-1:0]  retired
);
  state_t state, nxt;
  opcode_t op;
  logic bp_skip, halt_bp, adv, bp_hit, jump, we;
  logic [RIDX_W-1:0] ra, rb, rd;
  logic [DATA_W-1:0] a, b, imm, res;
  logic [AW-1:0] tgt, pc_inc;
  logic [63:0] iw;
  assign iw = 64'(imem_data);
  assign op = opcode_t'(3'(f_op(iw, RIDX_W)));
  assign ra = RIDX_W'(f_ra(iw, RIDX_W));
  assign rb = RIDX_W'(f_rb(iw, RIDX_W));
  assign rd = RIDX_W'(f_rd(iw, RIDX_W));
  assign tgt = AW'(f_tgt(iw, RIDX_W));
  assign imm = DATA_W'(f_imm(iw, RIDX_W));
  cpu_regfile #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) u_rf (
    .clk(clk), .rst_n(rst_n), .we(we), .wa(rd), .wd(res), .ra(ra), .rb(rb),
    .rdbg(dbg_sel), .qa(a), .qb(b), .qdbg(dbg_data)
  );
  assign imem_addr = pc;
  assign halted = state == ST_HALTED;
  assign adv = step_mode ? step : tick;
  assign bp_hit = bp_en && pc == bp_addr && !bp_skip;
  assign pc_inc = pc == AW'(IMEM_DEPTH - 1) ? '0 : pc + AW'(1);
  // Operands are decoded straight from imem_data during EXEC; ir only records it
  always_comb begin
    res = op == OP_ADD ? a + b : op == OP_SUB ? a - b : op == OP_AND ? a & b : imm;
    we = state == ST_EXEC && op inside {OP_ADD, OP_SUB, OP_AND, OP_LDI};
    jump = op == OP_JMP || (op == OP_BRZ && a == '0);
    nxt = state;
    if (state == ST_WAIT && adv) nxt = bp_hit ? ST_HALTED : ST_FETCH;
    if (state == ST_FETCH) nxt = ST_EXEC;
    if (state == ST_EXEC) nxt = op == OP_HALT ? ST_HALTED : ST_WAIT;
    if (state == ST_HALTED && resume) nxt = ST_WAIT;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ST_WAIT;
      pc <= '0;
      ir <= '0;
      alu_out <= '0;
      retired <= '0;
      bp_skip <= 1'b0;
      halt_bp <= 1'b0;
    end else begin
      state <= nxt;
      if (state == ST_WAIT && adv) begin
        if (bp_hit) halt_bp <= 1'b1;
        else bp_skip <= 1'b0;
      end
      if (state == ST_EXEC) begin
        ir <= imem_data;
        retired <= retired + CNT_W'(1);
        if (we) alu_out <= res;
        if (op == OP_HALT) halt_bp <= 1'b0;
        else pc <= jump ? tgt : pc_inc;
      end
      // A breakpoint halt re-enters the same pc once; a HALT opcode moves past it
      if (state == ST_HALTED && resume) begin
        if (halt_bp) bp_skip <= 1'b1;
        else pc <= pc_inc;
      end
    end
endmodule
